mem_burst_reader: RTL and testbench
===================================

# mem_burst_reader

Burst read initiator for the single-port neural-network weight/activation memory: on a start pulse it walks a contiguous (wrapping) address range of the memory, samples the memory's combinational read data and presents each word on a registered valid/ready output stream. It sits between a memory instance and the MAC/neuron datapath, sustaining one word per cycle when the consumer is ready. It never writes the memory.

## Interface
- `WIDTH`, 8, data word width; must match the attached memory.
- `SIZE`, 64, number of memory words; need not be a power of two. `AW` = `$clog2(SIZE)`.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — request a burst; sampled only in IDLE.
- `base_addr` in AW — first address of the burst; sampled with `start`.
- `length` in AW+1 — number of words; sampled with `start`; values > SIZE are saturated to SIZE.
- `mem_addr` out AW — address to memory (`addr` port); equals `fetch_ptr`.
- `mem_rd_data` in WIDTH — memory read data (`data_out` port), combinational in `mem_addr`.
- `out_data` out WIDTH — stream data, registered.
- `out_valid` out 1 — stream valid, registered.
- `out_ready` in 1 — consumer ready.
- `out_last` out 1 — marks the final word of the burst; valid only with `out_valid`.
- `busy` out 1 — high in FETCH, STREAM and DONE.
- `done` out 1 — one-cycle pulse at burst end.
- `stall_cycles` out 16 — present only with `MEM_BURST_READER_STALL_CNT_EN`.

## Operation
- Registers: `state`, `fetch_ptr` (AW), `remaining` (AW+1), `out_data`, `out_valid`, `out_last`.
- IDLE: `start` && length != 0 → latch `fetch_ptr` = base_addr, `remaining` = saturated length → FETCH. `start` && length == 0 → DONE (no beats). Otherwise stay.
- FETCH (exactly 1 cycle): `out_data` <= `mem_rd_data`; `out_valid` <= 1; `out_last` <= (remaining == 1); `fetch_ptr` advances → STREAM.
- STREAM: handshake = `out_valid && out_ready`. No handshake: all output registers hold. Handshake with remaining == 1: `out_valid` <= 0, `out_last` <= 0 → DONE. Handshake with remaining > 1: `out_data` <= `mem_rd_data`, `out_last` <= (remaining == 2), `remaining` decrements, `fetch_ptr` advances; `out_valid` stays 1.
- DONE (1 cycle): `done` = 1 → IDLE.
- Pointer advance: `fetch_ptr` == SIZE-1 → 0, else +1 (wrap independent of power-of-two).
- `start` outside IDLE is ignored, not queued.
- Coherence: each word reflects memory contents at the cycle it is fetched; concurrent writes to addresses already fetched are not seen.
- `out_data` is don't-care while `out_valid` = 0.

## Timing
- Reset values: state IDLE, `out_valid` 0, `out_last` 0, `out_data` 0, `busy` 0, `done` 0, `mem_addr` 0, `stall_cycles` 0.
- `rst` mid-burst: next edge returns to IDLE with the above values; partial burst discarded, no `done`.
- Latency: `start` at edge N → `out_valid` high after edge N+2 with word at `base_addr`.
- Throughput: 1 word/cycle with `out_ready` held high; burst of L words: `done` high in cycle N+2+L.
- `busy` rises after edge N+1 (FETCH), falls after the DONE cycle; a new `start` is accepted the cycle after `done`.
- Length-0: `done` pulse after edge N+1, `out_valid` never asserted.
- `out_valid` never deasserts without a handshake (AXI-stream rule); `out_data`/`out_last` stable while stalled.

## Configuration
- `MEM_BURST_READER_STALL_CNT_EN` defined: port `stall_cycles` exists; 16-bit counter increments each cycle with `out_valid && !out_ready`, saturates at 16'hFFFF, cleared to 0 when a burst is accepted in IDLE, holds value after burst ends.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Memory preloaded mem[i] = i+8'h10, SIZE 64; start base 4, length 3, `out_ready` = 1 → words 14,15,16 on consecutive cycles, `out_last` on 16, `done` one cycle later.
- Same burst, `out_ready` low for 3 cycles on second word → 15 held stable, sequence 14,15,16 unchanged, no duplicates/drops; with macro, `stall_cycles` = 3.
- Wrap: base 62, length 4 → addresses 62,63,0,1 → words 4E,4F,10,11; SIZE 48 variant, base 46 → 46,47,0,1.
- length 0 → `done` pulse 2 edges after start, `out_valid` never high; length 100 on SIZE 64 → exactly 64 words.
- `rst` asserted during the 2nd word of a 5-word burst → next cycle `out_valid` 0, `busy` 0, no `done`; fresh burst afterwards correct.
- `start` pulsed while STREAM → ignored; active burst completes unchanged, single `done`.

Source files
------------

// File: rtl/mem_burst_reader.sv
// Burst read initiator: walks a wrapping address range of a single-port memory and
// streams the words out on a registered valid/ready port. Optional stall counter: MEM_BURST_READER_STALL_CNT_EN.
module mem_burst_reader #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 64,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      length,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
`ifdef MEM_BURST_READER_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  // state  | meaning
  // IDLE   | waiting for start
  // FETCH  | first word sampled from memory into the output register
  // STREAM | word presented; next word fetched on each handshake
  // DONE   | one-cycle done pulse

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_t;

  localparam logic [AW:0]   SIZE_W   = (AW+1)'(SIZE);
  localparam logic [AW:0]   REM_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   REM_TWO  = (AW+1)'(2);
  localparam logic [AW-1:0] LAST_PTR = AW'(SIZE - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    fetch_ptr_q, fetch_ptr_d;
  logic [AW:0]      remaining_q, remaining_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      stall_q, stall_d;

  logic [AW-1:0]    ptr_next;
  logic [AW:0]      length_sat;
  logic             handshake;

  assign ptr_next   = (fetch_ptr_q == LAST_PTR) ? '0 : fetch_ptr_q + AW'(1);
  assign length_sat = (length > SIZE_W) ? SIZE_W : length;
  assign handshake  = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    stall_d     = stall_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          stall_d = '0;
          if (length == '0) begin
            state_d = S_DONE;
          end else begin
            fetch_ptr_d = base_addr;
            remaining_d = length_sat;
            state_d     = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        out_data_d  = mem_rd_data;
        out_valid_d = 1'b1;
        out_last_d  = (remaining_q == REM_ONE);
        fetch_ptr_d = ptr_next;
        state_d     = S_STREAM;
      end
      S_STREAM: begin
        if (out_valid_q && !out_ready && stall_q != 16'hFFFF) begin
          stall_d = stall_q + 16'd1;
        end
        if (handshake) begin
          if (remaining_q == REM_ONE) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_DONE;
          end else begin
            out_data_d  = mem_rd_data;
            out_last_d  = (remaining_q == REM_TWO);
            remaining_d = remaining_q - REM_ONE;
            fetch_ptr_d = ptr_next;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_ptr_q <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stall_q     <= stall_d;
    end
  end

  assign mem_addr  = fetch_ptr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef MEM_BURST_READER_STALL_CNT_EN
  assign stall_cycles = stall_q;
`else
  logic unused_stall;
  assign unused_stall = ^stall_q;
`endif

endmodule

// File: tb/tb_mem_burst_reader.sv
// Testbench for mem_burst_reader: two instances (SIZE 64 and SIZE 48) with memory models,
// directed and random bursts scored against an expected word list built from address arithmetic.
module tb_mem_burst_reader;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          out_ready;
  logic [AW-1:0] mem_addr [2];
  logic [7:0]    mem_rd_data [2];
  logic [7:0]    out_data [2];
  logic          out_valid [2];
  logic          out_last [2];
  logic          busy [2];
  logic          done [2];
`ifdef MEM_BURST_READER_STALL_CNT_EN
  logic [15:0]   stall_cycles [2];
`endif
  logic [7:0]    mem [2][64];

  int checks = 0;
  int failures = 0;
  int sizes [2] = '{64, 48};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign mem_rd_data[g] = mem[g][mem_addr[g]];
    mem_burst_reader #(.WIDTH(8), .SIZE((g == 0) ? 64 : 48)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start[g]),
      .base_addr   (base_addr),
      .length      (length),
      .mem_addr    (mem_addr[g]),
      .mem_rd_data (mem_rd_data[g]),
      .out_data    (out_data[g]),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready),
      .out_last    (out_last[g]),
      .busy        (busy[g]),
      .done        (done[g])
`ifdef MEM_BURST_READER_STALL_CNT_EN
      ,
      .stall_cycles(stall_cycles[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low 3 cycles on the second word
  task automatic run_burst(input int sel, input int base, input int len, input int mode, input int pulse_at);
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    int exp_n, done_cnt, done_cyc, stalls, hold_cnt;
    logic prev_stall, rdy;
    logic [7:0] prev_data;
    logic prev_last;
    exp_n = (len > sizes[sel]) ? sizes[sel] : len;
    for (int i = 0; i < exp_n; i++) exp_q.push_back(mem[sel][(base + i) % sizes[sel]]);
    done_cnt = 0; done_cyc = 0; stalls = 0; hold_cnt = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    @(negedge clk);
    start = '0;
    start[sel] = 1'b1;
    base_addr = AW'(base);
    length = (AW+1)'(len);
    out_ready = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      start = '0;
      if (cyc == pulse_at) begin
        start[sel] = 1'b1;
        base_addr = '0;
        length = 7'd7;
      end
      if (done[sel]) begin
        done_cnt++;
        done_cyc = cyc;
      end
      chk("busy", busy[sel], (done_cnt == 0) || (cyc == done_cyc));
      if (len == 0) chk("len0_no_valid", out_valid[sel], 1'b0);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = 1'b1;
          if (out_valid[sel] && got.size() == 1 && hold_cnt < 3) begin
            rdy = 1'b0;
            hold_cnt++;
          end
        end
      endcase
      out_ready = rdy;
      if (out_valid[sel]) begin
        if (prev_stall) begin
          chk("stall_data_stable", out_data[sel], prev_data);
          chk("stall_last_stable", out_last[sel], prev_last);
        end
        if (rdy) begin
          got.push_back(out_data[sel]);
          chk("last_flag", out_last[sel], got.size() == exp_n);
        end else begin
          stalls++;
        end
        prev_stall = !rdy;
        prev_data = out_data[sel];
        prev_last = out_last[sel];
      end else begin
        prev_stall = 1'b0;
      end
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
    end
    start = '0;
    out_ready = 1'b1;
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_cyc, (exp_n == 0) ? 1 : exp_n + 2 + stalls);
    chk("beat_count", got.size(), exp_n);
    for (int i = 0; i < exp_n && i < got.size(); i++) chk("beat_data", got[i], exp_q[i]);
`ifdef MEM_BURST_READER_STALL_CNT_EN
    chk("stall_cycles", stall_cycles[sel], stalls);
`endif
  endtask

  initial begin
    int dcnt;
    rst = 1'b1;
    start = '0;
    base_addr = '0;
    length = '0;
    out_ready = 1'b1;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 64; i++) mem[g][i] = 8'(i + 16);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_valid", out_valid[g], 1'b0);
      chk("rst_last", out_last[g], 1'b0);
      chk("rst_data", out_data[g], 8'h00);
      chk("rst_busy", busy[g], 1'b0);
      chk("rst_done", done[g], 1'b0);
      chk("rst_addr", mem_addr[g], 6'd0);
    end
    rst = 1'b0;

    run_burst(0, 4, 3, 0, 0);
    run_burst(0, 4, 3, 2, 0);
    run_burst(0, 62, 4, 0, 0);
    run_burst(1, 46, 4, 0, 0);
    run_burst(0, 9, 0, 0, 0);
    run_burst(0, 5, 100, 0, 0);
    run_burst(1, 30, 100, 1, 0);
    run_burst(0, 20, 6, 0, 3);

    // reset while the second word of a 5-word burst is presented
    @(negedge clk);
    start[0] = 1'b1;
    base_addr = 6'd10;
    length = 7'd5;
    @(negedge clk);
    start = '0;
    repeat (2) @(negedge clk);
    chk("pre_rst_word2", out_data[0], mem[0][11]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", out_valid[0], 1'b0);
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_done", done[0], 1'b0);
    chk("midrst_addr", mem_addr[0], 6'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done[0] || out_valid[0]) dcnt++;
    end
    chk("post_rst_quiet", dcnt, 0);
    run_burst(0, 10, 5, 0, 0);

    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 64; i++) mem[g][i] = 8'($urandom);
    for (int t = 0; t < 24; t++) begin
      int sel;
      sel = $urandom_range(0, 1);
      run_burst(sel, $urandom_range(0, sizes[sel] - 1), $urandom_range(0, 80), 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
